// File: rtl/alu_sequencer.sv
// Single-issue IDLE/DECODE/EXEC/WB sequencer driving an external combinational ALU,
// with a 16x16 register file and PSR. Optional macro ALU_SEQ_R0_ZERO_EN hard-wires R0 to zero.
module alu_sequencer #(
  parameter int REGS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [7:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_carry,
  input  logic [15:0] alu_c,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  psr,
  output logic        done,
  output logic        illegal,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] instr_q;
  logic [7:0]  alu_op_q;
  logic [15:0] alu_a_q, alu_b_q;
  logic [15:0] result_q;
  logic [4:0]  psr_q;
  logic        illegal_q;
  logic [15:0] regs_q [REGS];

  logic [3:0]  op, rd, ext, rs;
  logic [7:0]  imm8;
  logic [15:0] rd_val, rs_val, dbg_val;
  logic        dec_legal;
  logic [7:0]  dec_op;
  logic [15:0] dec_a, dec_b;
  logic        handshake;
  logic        is_cmp;
  logic        wb_en;

  assign op   = instr_q[15:12];
  assign rd   = instr_q[11:8];
  assign ext  = instr_q[7:4];
  assign rs   = instr_q[3:0];
  assign imm8 = instr_q[7:0];

  // Register-file read ports; R0 reads as zero when the option is enabled.
  always_comb begin
    rd_val  = regs_q[rd];
    rs_val  = regs_q[rs];
    dbg_val = regs_q[dbg_addr];
`ifdef ALU_SEQ_R0_ZERO_EN
    if (rd == 4'd0)       rd_val  = '0;
    if (rs == 4'd0)       rs_val  = '0;
    if (dbg_addr == 4'd0) dbg_val = '0;
`endif
  end

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    dec_legal = 1'b1;
    dec_op    = {op, 4'b0000};
    dec_a     = rd_val;
    dec_b     = '0;
    case (op)
      4'h0, 4'h8: begin
        dec_op = {op, ext};
        if ((op == 4'h8 && !ext[2]) || (op == 4'h0 && ext == 4'hC))
          dec_b = {12'b0, rs};
        else
          dec_b = rs_val;
      end
      4'h5, 4'h7, 4'h9, 4'hB: dec_b = {{8{imm8[7]}}, imm8};
      4'h1, 4'h2, 4'h3, 4'h4, 4'h6: dec_b = {8'b0, imm8};
      default: dec_legal = 1'b0;
    endcase
  end

  assign handshake = instr_valid && instr_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (handshake) state_d = S_DECODE;
      S_DECODE: state_d = dec_legal ? S_EXEC : S_IDLE;
      S_EXEC:   state_d = S_WB;
      default:  state_d = S_IDLE;
    endcase
  end

  // Compares update only the PSR.
  assign is_cmp = (alu_op_q == 8'h0B) || (alu_op_q == 8'hB0) ||
                  (alu_op_q == 8'h08) || (alu_op_q == 8'h0C);
`ifdef ALU_SEQ_R0_ZERO_EN
  assign wb_en = !is_cmp && (rd != 4'd0);
`else
  assign wb_en = !is_cmp;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      result_q  <= '0;
      psr_q     <= '0;
      illegal_q <= 1'b0;
      // NOTE: the register file is architecturally cleared by reset, so it cannot map to plain RAM.
      for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= (state_q == S_DECODE) && !dec_legal;
      if (handshake) instr_q <= instr;
      if (state_q == S_DECODE && dec_legal) begin
        alu_op_q <= dec_op;
        alu_a_q  <= dec_a;
        alu_b_q  <= dec_b;
      end
      if (state_q == S_EXEC) begin
        result_q <= alu_c;
        psr_q    <= alu_flags;
      end
      if (state_q == S_WB && wb_en) regs_q[rd] <= result_q;
    end
  end

  assign instr_ready = (state_q == S_IDLE) && !reset;
  assign done        = (state_q == S_WB) && !reset;
  assign illegal     = illegal_q;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_carry   = psr_q[3];
  assign psr         = psr_q;
  assign dbg_data    = dbg_val;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: stand-in ALU, directed vector table, corner sequences,
// and randomized instructions against an architectural register/PSR model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [7:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        alu_carry;
  logic [15:0] alu_c;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        done, illegal;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_carry(alu_carry), .alu_c(alu_c), .alu_flags(alu_flags), .psr(psr),
    .done(done), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Stand-in ALU: adds/compares behave realistically, other opcodes use a mixing function.
  function automatic logic [20:0] alu_fn(input logic [7:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic [15:0] c;
    logic [4:0]  f;
    logic        lt;
    case (op)
      8'h60, 8'h50, 8'h40: begin
        s = {1'b0, a} + {1'b0, b} + ((op == 8'h40) ? {16'b0, cin} : 17'd0);
        c = s[15:0];
        f = {c == 16'd0, s[16], (a[15] == b[15]) && (c[15] != a[15]), 2'b00};
      end
      8'h0B, 8'hB0: begin
        lt = $signed(a) < $signed(b);
        c  = a;
        f  = {a == b, 2'b00, lt, lt};
      end
      8'h08, 8'h0C: begin
        lt = a < b;
        c  = a;
        f  = {a == b, 2'b00, lt, lt};
      end
      default: begin
        c = (a ^ {op, op}) + b + {15'b0, cin};
        f = c[4:0] ^ op[4:0];
      end
    endcase
    return {c, f};
  endfunction

  always_comb {alu_c, alu_flags} = alu_fn(alu_op, alu_a, alu_b, alu_carry);

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Architectural model
  logic [15:0] m_regs [16];
  logic [4:0]  m_psr;

  function automatic logic [15:0] m_rd(input logic [3:0] i);
`ifdef ALU_SEQ_R0_ZERO_EN
    if (i == 4'd0) return 16'd0;
`endif
    return m_regs[i];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'd0;
    m_psr = 5'd0;
  endtask

  // Issue one instruction and follow it to completion, checking each cycle against the model.
  task automatic issue(input logic [15:0] ins, output int waited);
    int          n;
    logic [3:0]  op, rd;
    logic [7:0]  e_op;
    logic [15:0] e_a, e_b;
    logic [20:0] r;
    logic        legal, cmp, wr;
    n = 0;
    while (!instr_ready && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    waited = n;
    if (!instr_ready) begin
      check("ready_timeout", 32'(instr_ready), 32'd1);
      return;
    end
    op = ins[15:12];
    rd = ins[11:8];
    legal = !(op == 4'hA || op >= 4'hC);
    instr_valid = 1'b1;
    instr = ins;
    dbg_addr = rd;
    @(posedge clk); #1;
    // DECODE: new requests must be ignored while busy
    instr_valid = 1'($urandom_range(0, 1));
    instr = 16'($urandom);
    check("decode_ready", 32'(instr_ready), 32'd0);
    check("decode_done", 32'(done), 32'd0);
    check("decode_illegal", 32'(illegal), 32'd0);
    @(posedge clk); #1;
    if (!legal) begin
      instr_valid = 1'b0;
      check("illegal_pulse", 32'(illegal), 32'd1);
      check("illegal_done", 32'(done), 32'd0);
      check("illegal_ready", 32'(instr_ready), 32'd1);
      check("illegal_psr", 32'(psr), 32'(m_psr));
      check("illegal_reg", 32'(dbg_data), 32'(m_rd(rd)));
      return;
    end
    if (op == 4'h0 || op == 4'h8) begin
      e_op = {op, ins[7:4]};
      if ((op == 4'h8 && !ins[6]) || (op == 4'h0 && ins[7:4] == 4'hC)) e_b = {12'b0, ins[3:0]};
      else e_b = m_rd(ins[3:0]);
    end else begin
      e_op = {op, 4'h0};
      if (op == 4'h5 || op == 4'h7 || op == 4'h9 || op == 4'hB) e_b = {{8{ins[7]}}, ins[7:0]};
      else e_b = {8'h00, ins[7:0]};
    end
    e_a = m_rd(rd);
    check("exec_op", 32'(alu_op), 32'(e_op));
    check("exec_a", 32'(alu_a), 32'(e_a));
    check("exec_b", 32'(alu_b), 32'(e_b));
    check("exec_carry", 32'(alu_carry), 32'(m_psr[3]));
    check("exec_done", 32'(done), 32'd0);
    r = alu_fn(e_op, e_a, e_b, m_psr[3]);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("wb_done", 32'(done), 32'd1);
    check("wb_ready", 32'(instr_ready), 32'd0);
    check("wb_old_reg", 32'(dbg_data), 32'(m_rd(rd)));
    @(posedge clk); #1;
    cmp = (e_op == 8'h0B) || (e_op == 8'hB0) || (e_op == 8'h08) || (e_op == 8'h0C);
    wr = !cmp;
`ifdef ALU_SEQ_R0_ZERO_EN
    if (rd == 4'd0) wr = 1'b0;
`endif
    m_psr = r[4:0];
    if (wr) m_regs[rd] = r[20:5];
    check("idle_done", 32'(done), 32'd0);
    check("idle_ready", 32'(instr_ready), 32'd1);
    check("wb_reg", 32'(dbg_data), 32'(m_rd(rd)));
    check("wb_psr", 32'(psr), 32'(m_psr));
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [3:0]  reg_idx;
    logic [15:0] exp_val;
    logic [4:0]  exp_psr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int w;
    logic [15:0] rnd;
    vecs[0] = '{16'h61FF, 4'd1, 16'h00FF, 5'b00000};
    vecs[1] = '{16'h5280, 4'd2, 16'hFF80, 5'b00000};
    vecs[2] = '{16'h01B2, 4'd1, 16'h00FF, 5'b00000};
    vecs[3] = '{16'h0182, 4'd1, 16'h00FF, 5'b00011};
    vecs[4] = '{16'h53FF, 4'd3, 16'hFFFF, 5'b00000};
    vecs[5] = '{16'h6301, 4'd3, 16'h0000, 5'b11000};
    vecs[6] = '{16'h4400, 4'd4, 16'h0001, 5'b00000};

    m_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = 16'd0;
    dbg_addr = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_op", 32'(alu_op), 32'h00);
    check("rst_a", 32'(alu_a), 32'd0);
    check("rst_b", 32'(alu_b), 32'd0);
    check("rst_psr", 32'(psr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      check("rst_reg", 32'(dbg_data), 32'd0);
    end

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].ins, w);
      dbg_addr = vecs[i].reg_idx;
      #1;
      check("vec_reg", 32'(dbg_data), 32'(vecs[i].exp_val));
      check("vec_psr", 32'(psr), 32'(vecs[i].exp_psr));
    end

    // Illegal instruction, then a legal one taken on the very next edge
    issue(16'hF123, w);
    check("illegal_psr_kept", 32'(psr), 32'd0);
    issue(16'h1000, w);
    check("accept_at_n2", 32'(w), 32'd0);

    // Reset during EXEC aborts without writeback
    instr_valid = 1'b1;
    instr = 16'h6155;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_exec_op", 32'(alu_op), 32'h60);
    reset = 1'b1;
    m_reset();
    @(posedge clk); #1;
    check("abort_ready", 32'(instr_ready), 32'd0);
    check("abort_op", 32'(alu_op), 32'h00);
    check("abort_psr", 32'(psr), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    dbg_addr = 4'd1;
    #1;
    check("abort_r1", 32'(dbg_data), 32'd0);
    reset = 1'b0;
    #1;
    check("abort_ready_after", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    check("abort_no_done", 32'(done), 32'd0);

    // R0 behaviour
    issue(16'h6012, w);
    check("r0_accept", 32'(w), 32'd0);
    dbg_addr = 4'd0;
    #1;
`ifdef ALU_SEQ_R0_ZERO_EN
    check("r0_zero", 32'(dbg_data), 32'h0000);
`else
    check("r0_plain", 32'(dbg_data), 32'h0012);
`endif
    check("r0_psr", 32'(psr), 32'd0);

    // Randomized instruction stream
    for (int k = 0; k < 150; k++) begin
      rnd = 16'($urandom);
      issue(rnd, w);
    end
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      check("final_reg", 32'(dbg_data), 32'(m_rd(4'(i))));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Single-issue instruction sequencer that drives the combinational ALU: it accepts 16-bit instructions, decodes them into the ALU's 8-bit opcode and operands, and reads registers from an internal 16×16 register file. It then captures the ALU result and 5-bit flags, writing back to the register file and the processor status register (PSR). The block is the initiator side of the ALU interface and sits between instruction fetch and the ALU in the datapath.

## Interface
Parameters:
- `REGS`, 16: register count. Fixed; the 4-bit register fields depend on it.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  `instr` holds an instruction.
- `instr`  in  16  instruction word.
- `instr_ready`  out  1  sequencer can accept; handshake when `instr_valid & instr_ready`.
- `alu_op`  out  8  ALU opcode.
- `alu_a`  out  16  ALU operand A.
- `alu_b`  out  16  ALU operand B.
- `alu_carry`  out  1  ALU carry-in; always equals `psr[3]`.
- `alu_c`  in  16  ALU result.
- `alu_flags`  in  5  ALU flags, ordered {Z, C, F, L, N}.
- `psr`  out  5  status register.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  one-cycle pulse when an instruction is rejected.
- `dbg_addr`  in  4  debug read address.
- `dbg_data`  out  16  combinational read of `reg[dbg_addr]`.

## Operation
Fields:
- op = `instr[15:12]`, rd = `[11:8]`, ext = `[7:4]`, rs = `[3:0]`, imm8 = `[7:0]`.

Decode rules:
- **Register form** (op 0000 or 1000): `alu_op`={op,ext}; A=reg[rd], B=reg[rs].
  - Exception: op 1000 with ext[2]=0 (immediate shifts) and op 0000 with ext 1100 (CMPUI) use B={12'b0, rs}.
- **Immediate form** (op 0001–0111, 1001, 1011): `alu_op`={op,4'b0000}; A=reg[rd].
  - B = sign-extended imm8 for op 0101, 0111, 1001, 1011.
  - B = zero-extended imm8 for op 0001, 0010, 0011, 0100, 0110.
- **Illegal**: op 1010, 1100–1111.
  - No ALU cycle, no writeback, PSR unchanged.
  - `illegal` pulses one cycle.

Writeback:
- C is written to reg[rd] for all legal ops except compares (opcodes 0x0B, 0xB0, 0x08, 0x0C), which update only the PSR.
- `psr` <= `alu_flags` at the end of EXEC for every legal op.

State machine (states IDLE, DECODE, EXEC, WB):
- IDLE: `instr_ready`=1. On handshake, latch `instr` and go to DECODE.
- DECODE: register `alu_op`/`alu_a`/`alu_b`. Go to EXEC, or to IDLE with `illegal` set if the op is illegal.
- EXEC: ALU settles. At the edge, capture `alu_c` into the result register and `alu_flags` into `psr`, then go to WB.
- WB: `done`=1. Write the result register file at the edge, then go to IDLE.
- While not in IDLE, `alu_op`/`alu_a`/`alu_b` hold their values; `instr_valid` is ignored.

Reset:
- State goes to IDLE; all registers and `psr` are cleared to 0.
- `alu_op`=8'h00 (NOP), `alu_a`=`alu_b`=0, `done`=`illegal`=0.
- `instr_ready`=0 while `reset` is high and 1 on the first cycle after.
- Reset in any state aborts the instruction with no writeback.

## Timing
- Handshake at edge N → DECODE in cycle N+1 → EXEC in N+2 → WB in N+3 (`done` high) → IDLE in N+4.
- The regfile write lands at the end of N+3; `dbg_data` shows it from N+4.
- Throughput is one instruction per 4 cycles. No overlap, so no forwarding is needed.
- An illegal instruction handshaken at N returns to IDLE at N+2, with `illegal` high during N+2.
- `alu_carry` reflects `psr` from the previous retired instruction.
- Source and destination the same (rd==rs) reads the old value; the write occurs only in WB.

## Configuration
- `ALU_SEQ_R0_ZERO_EN` defined:
  - reg[0] always reads 0, and writes to rd=0 are discarded.
  - PSR still updates.
- Not defined: R0 is an ordinary register.

## Test plan
- Reset; issue 0x61FF (ADDUI R1,#0xFF) → `done` 3 cycles after the handshake; R1=0x00FF; `psr`=5'b00000; `instr_ready` high again at N+4.
- Issue 0x5280 (ADDI R2,#0x80) → R2=0xFF80. Then:
  - 0x01B2 (CMP R1,R2) → `psr`=5'b00000, R1 unchanged.
  - 0x0182 (CMPU R1,R2) → `psr`=5'b00011, R1 unchanged.
- Issue 0x53FF (R3=0xFFFF), then 0x6301 (ADDUI R3,#1) → R3=0x0000, `psr`=5'b11000. Then 0x4400 (ADDCUI R4,#0) → `alu_carry`=1, R4=0x0001, `psr`=5'b00000.
- Issue 0xF123 → `illegal` pulses in cycle N+2; `done` stays 0; no register or `psr` change. Then 0x1000 is accepted at N+2.
- Assert `reset` during EXEC of 0x6155 → no writeback; R1=0, `psr`=0, `alu_op`=0x00; next instruction is accepted normally.
- With `ALU_SEQ_R0_ZERO_EN`: 0x6012 → `dbg_data`@0 = 0x0000, `psr`=5'b00000. Without it: R0=0x0012.
